// File: rtl/quad_snapshot_ctrl_if.sv
// Command, counter and read-byte signals between the I2C slave side and the snapshot sequencer.
// The master side issues commands and read requests; the slave side is quad_snapshot_ctrl.
interface quad_snapshot_ctrl_if #(
    parameter int NCH = 4,
    parameter int CW  = 16
);
    logic [7:0]        CMD;
    logic              CMD_VLD;
    logic              TEND;
    logic [NCH*CW-1:0] CNTR;
    logic [NCH-1:0]    CLR;
    logic              FREEZE;
    logic              RD_REQ;
    logic [7:0]        RD_DATA;
    logic              RD_VLD;
    logic              BUSY;
    logic              ERR;

    modport master (
        output CMD, CMD_VLD, TEND, CNTR, RD_REQ,
        input  CLR, FREEZE, RD_DATA, RD_VLD, BUSY, ERR
    );

    modport slave (
        input  CMD, CMD_VLD, TEND, CNTR, RD_REQ,
        output CLR, FREEZE, RD_DATA, RD_VLD, BUSY, ERR
    );
endinterface

// File: rtl/quad_snapshot_ctrl.sv
// Decodes I2C command bytes, takes an atomic snapshot of all counters, issues clears and serves bytes.
// Snapshot lands one cycle after the command; reads answer one cycle after RD_REQ; commands while BUSY are dropped and flag ERR.
module quad_snapshot_ctrl #(
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input logic                 CLCK,
    input logic                 RST,
    quad_snapshot_ctrl_if.slave bus
);
    localparam int NB  = NCH * CW / 8;
    localparam int BPC = CW / 8;
    localparam int PW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(NB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CLRWAIT,
        ST_READ
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NCH*CW-1:0] snap_q, snap_d;
    logic [NCH-1:0]    clr_q, clr_d;
    logic              err_q, err_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_vld_q, rd_vld_d;

    logic              busy;
    logic [7:0]        rd_byte;
    logic [3:0]        cmd_hi;
    logic [3:0]        cmd_n;
    logic              n_ok;

    assign busy   = (state_q == ST_CAPTURE) || (state_q == ST_CLRWAIT);
    assign cmd_hi = bus.CMD[7:4];
    assign cmd_n  = bus.CMD[3:0];
    assign n_ok   = 32'(cmd_n) < NCH;

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (ptr_q == PW'(i)) begin
                rd_byte = snap_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        snap_d    = snap_q;
        clr_d     = '0;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;

        if (state_q == ST_CAPTURE) begin
            snap_d  = bus.CNTR;
            ptr_d   = '0;
            state_d = ST_CLRWAIT;
        end
        if (state_q == ST_CLRWAIT) begin
            state_d = ST_READ;
        end

        // Read is served from the current snapshot/ptr before TEND or a command can move them.
        if (bus.RD_REQ) begin
            rd_vld_d = 1'b1;
            if (state_q == ST_READ) begin
                rd_data_d = rd_byte;
                ptr_d     = (ptr_q == PTR_MAX) ? '0 : ptr_q + PW'(1);
            end else begin
                rd_data_d = 8'hFF;
            end
        end

        if (bus.TEND && !busy) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
        end

        if (bus.CMD_VLD) begin
            if (busy) begin
                err_d = 1'b1;
            end else begin
                case (bus.CMD)
                    8'h01: state_d = ST_CAPTURE;
                    8'h02: begin
                        state_d = ST_CAPTURE;
                        clr_d   = '1;
                    end
                    8'h03: err_d = 1'b0;
                    default: begin
                        if (cmd_hi == 4'h1 && n_ok) begin
                            for (int i = 0; i < NCH; i++) begin
                                if (cmd_n == 4'(i)) begin
                                    clr_d[i] = 1'b1;
                                end
                            end
                        end else if (cmd_hi == 4'h2 && n_ok) begin
                            ptr_d   = PW'(32'(cmd_n) * BPC);
                            state_d = ST_READ;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLCK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            snap_q    <= '0;
            clr_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= 8'h00;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            snap_q    <= snap_d;
            clr_q     <= clr_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign bus.CLR     = clr_q;
    assign bus.FREEZE  = (state_q == ST_CAPTURE);
    assign bus.RD_DATA = rd_data_q;
    assign bus.RD_VLD  = rd_vld_q;
    assign bus.BUSY    = busy;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_quad_snapshot_ctrl.sv
// Directed bench for quad_snapshot_ctrl: inputs change and outputs are sampled on the falling edge.
// Four counters are modelled locally so clear pulses and snapshot coherence can be observed.
module tb_quad_snapshot_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [15:0] cnt [4];
    logic [15:0] ld_val [4];
    logic        ld;
    logic        inc_en;
    logic [63:0] exp_snap;

    quad_snapshot_ctrl_if #(.NCH(4), .CW(16)) bus ();

    quad_snapshot_ctrl #(.NCH(4), .CW(16)) dut (
        .CLCK (clk),
        .RST  (rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ld)              cnt[i] <= ld_val[i];
            else if (bus.CLR[i]) cnt[i] <= 16'h0000;
            else if (inc_en)     cnt[i] <= cnt[i] + 16'h0001;
        end
    end

    assign bus.CNTR = {cnt[3], cnt[2], cnt[1], cnt[0]};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bus.CMD     = c;
        bus.CMD_VLD = 1'b1;
        tick();
        bus.CMD_VLD = 1'b0;
    endtask

    task automatic do_rd(input string tag, input logic [7:0] exp);
        bus.RD_REQ = 1'b1;
        tick();
        bus.RD_REQ = 1'b0;
        chk({tag, "_vld"}, 64'(bus.RD_VLD), 64'd1);
        chk(tag, 64'(bus.RD_DATA), 64'(exp));
    endtask

    task automatic pulse_tend();
        bus.TEND = 1'b1;
        tick();
        bus.TEND = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.CMD = 8'h00;
        bus.CMD_VLD = 1'b0;
        bus.TEND = 1'b0;
        bus.RD_REQ = 1'b0;
        inc_en = 1'b0;
        ld = 1'b1;
        ld_val[0] = 16'h1234;
        ld_val[1] = 16'h00FF;
        ld_val[2] = 16'h8000;
        ld_val[3] = 16'hFFFF;
        tick();
        tick();
        chk("rst_clr",    64'(bus.CLR),     64'h0);
        chk("rst_freeze", 64'(bus.FREEZE),  64'h0);
        chk("rst_rddata", 64'(bus.RD_DATA), 64'h00);
        chk("rst_rdvld",  64'(bus.RD_VLD),  64'h0);
        chk("rst_busy",   64'(bus.BUSY),    64'h0);
        chk("rst_err",    64'(bus.ERR),     64'h0);
        rst = 1'b0;
        ld = 1'b0;
        tick();

        // SNAP, then full read-out with wrap
        send_cmd(8'h01);
        chk("snap_freeze_t1", 64'(bus.FREEZE), 64'h1);
        chk("snap_busy_t1",   64'(bus.BUSY),   64'h1);
        chk("snap_clr_t1",    64'(bus.CLR),    64'h0);
        tick();
        chk("snap_busy_t2",   64'(bus.BUSY),   64'h1);
        chk("snap_freeze_t2", 64'(bus.FREEZE), 64'h0);
        tick();
        chk("snap_busy_t3",   64'(bus.BUSY),   64'h0);
        do_rd("rd0", 8'h34);
        do_rd("rd1", 8'h12);
        do_rd("rd2", 8'hFF);
        do_rd("rd3", 8'h00);
        do_rd("rd4", 8'h00);
        do_rd("rd5", 8'h80);
        do_rd("rd6", 8'hFF);
        do_rd("rd7", 8'hFF);
        do_rd("rd_wrap", 8'h34);

        // Single-channel clear and channel select
        send_cmd(8'h12);
        chk("clr2_pulse", 64'(bus.CLR),  64'h4);
        chk("clr2_busy",  64'(bus.BUSY), 64'h0);
        tick();
        chk("clr2_end",   64'(bus.CLR),  64'h0);
        chk("clr2_cnt",   64'(cnt[2]),   64'h0);
        send_cmd(8'h23);
        do_rd("ch3_lo", 8'hFF);
        do_rd("ch3_hi", 8'hFF);

        // Error flag: bad command, dropped command while busy, clear
        send_cmd(8'h55);
        chk("bad_err",    64'(bus.ERR),    64'h1);
        chk("bad_clr",    64'(bus.CLR),    64'h0);
        chk("bad_freeze", 64'(bus.FREEZE), 64'h0);
        send_cmd(8'h03);
        chk("errclr1", 64'(bus.ERR), 64'h0);
        bus.CMD = 8'h01;
        bus.CMD_VLD = 1'b1;
        tick();
        chk("dbl_freeze1", 64'(bus.FREEZE), 64'h1);
        tick();
        bus.CMD_VLD = 1'b0;
        chk("dbl_err",     64'(bus.ERR),    64'h1);
        chk("dbl_freeze2", 64'(bus.FREEZE), 64'h0);
        chk("dbl_busy",    64'(bus.BUSY),   64'h1);
        tick();
        chk("dbl_ready",   64'(bus.BUSY),   64'h0);
        send_cmd(8'h03);
        chk("errclr2", 64'(bus.ERR), 64'h0);

        // Snapshot now 34 12 FF 00 00 00 FF FF; idle reads and TEND handling
        pulse_tend();
        do_rd("idle_rd", 8'hFF);
        send_cmd(8'h20);
        do_rd("s2_b0", 8'h34);
        do_rd("s2_b1", 8'h12);
        do_rd("s2_b2", 8'hFF);
        pulse_tend();
        do_rd("tend_rd", 8'hFF);
        send_cmd(8'h20);
        do_rd("s2_b0b", 8'h34);
        bus.CMD = 8'h22;
        bus.CMD_VLD = 1'b1;
        bus.RD_REQ = 1'b1;
        tick();
        bus.CMD_VLD = 1'b0;
        bus.RD_REQ = 1'b0;
        chk("cmdrd_vld",  64'(bus.RD_VLD),  64'h1);
        chk("cmdrd_data", 64'(bus.RD_DATA), 64'h12);
        do_rd("cmdrd_next", 8'h00);
        bus.CMD = 8'h20;
        bus.CMD_VLD = 1'b1;
        bus.TEND = 1'b1;
        tick();
        bus.CMD_VLD = 1'b0;
        bus.TEND = 1'b0;
        do_rd("cmdtend_rd", 8'h34);

        // SNAP_CLR on running counters
        pulse_tend();
        inc_en = 1'b1;
        tick();
        tick();
        tick();
        send_cmd(8'h02);
        exp_snap = {cnt[3], cnt[2], cnt[1], cnt[0]};
        chk("sc_freeze", 64'(bus.FREEZE), 64'h1);
        chk("sc_clr",    64'(bus.CLR),    64'hF);
        chk("sc_busy1",  64'(bus.BUSY),   64'h1);
        tick();
        chk("sc_cnt_zero", {cnt[3], cnt[2], cnt[1], cnt[0]}, 64'h0);
        chk("sc_busy2",  64'(bus.BUSY),   64'h1);
        chk("sc_clr_end", 64'(bus.CLR),   64'h0);
        tick();
        chk("sc_busy3",  64'(bus.BUSY),   64'h0);
        for (int i = 0; i < 8; i++) begin
            do_rd("sc_rd", exp_snap[i*8 +: 8]);
        end
        send_cmd(8'h20);
        do_rd("sc_hold", exp_snap[7:0]);
        inc_en = 1'b0;

        // Reset in the middle of a capture
        send_cmd(8'h55);
        bus.CMD = 8'h01;
        bus.CMD_VLD = 1'b1;
        tick();
        bus.CMD_VLD = 1'b0;
        chk("mr_capture", 64'(bus.FREEZE), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_freeze", 64'(bus.FREEZE),  64'h0);
        chk("mr_busy",   64'(bus.BUSY),    64'h0);
        chk("mr_clr",    64'(bus.CLR),     64'h0);
        chk("mr_rdvld",  64'(bus.RD_VLD),  64'h0);
        chk("mr_rddata", 64'(bus.RD_DATA), 64'h00);
        chk("mr_err",    64'(bus.ERR),     64'h0);
        send_cmd(8'h20);
        do_rd("mr_rd0", 8'h00);
        do_rd("mr_rd1", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/quad_snapshot_ctrl.md
Name: quad_snapshot_ctrl

Overview:
Command sequencer between the I2C slave and the four quadrature counters. It decodes command bytes received over I2C and, in response, takes an atomic snapshot of all counters, issues per-channel or global clears, and serves the snapshot to the I2C slave byte-serially through a request/valid handshake. With the snapshot, the I2C master reads one coherent set of counts even though the counters keep running.

Parameters:
NCH, 4, number of counter channels (1..8)
CW, 16, counter width in bits; must be a multiple of 8
NB, NCH*CW/8, derived: number of snapshot bytes (8 at defaults)

Ports:
CLCK  in  1  system clock; all logic on rising edge
RST  in  1  reset, synchronous, active-high
CMD  in  8  command byte from the I2C slave
CMD_VLD  in  1  one-cycle strobe; CMD is valid this cycle
TEND  in  1  one-cycle strobe at the end of an I2C transaction (STOP)
CNTR  in  NCH*CW  live counts, packed; channel 0 in bits [CW-1:0]
CLR  out  NCH  one-cycle clear pulse per counter channel
FREEZE  out  1  high during the cycle the snapshot is captured
RD_REQ  in  1  one-cycle strobe; I2C slave requests the next read byte
RD_DATA  out  8  read byte
RD_VLD  out  1  one-cycle strobe; RD_DATA is valid
BUSY  out  1  high while the FSM is not accepting commands
ERR  out  1  sticky error flag

Behaviour:
- Reset (RST high at a clock edge), regardless of state, including mid-capture or mid-read:
  - state=IDLE, ptr=0, all snapshot registers=0
  - CLR=0, FREEZE=0, RD_DATA=8'h00, RD_VLD=0, BUSY=0, ERR=0
- FSM states: IDLE, CAPTURE, CLRWAIT, READ.
- Command decode (acted on only in IDLE or READ):
  - 8'h01 SNAP: go to CAPTURE.
  - 8'h02 SNAP_CLR: go to CAPTURE with the clear flag set.
  - 8'h03 ERR_CLR: ERR<=0; state unchanged.
  - 8'h1n, n<NCH: CLR[n]=1 in the next cycle only; state unchanged.
  - 8'h2n, n<NCH: ptr<=n*CW/8; state<=READ; no new snapshot is taken.
  - Any other value, including n>=NCH: ERR<=1; command ignored.
- Command timing: CMD_VLD at cycle t puts the FSM in CAPTURE at t+1.
  - In t+1: FREEZE=1 and BUSY=1; the snapshot registers load CNTR as sampled in t+1, all channels in the same edge.
  - SNAP_CLR also asserts CLR={NCH{1}} in t+1, so snapshot and clear coincide. Edges arriving in t+1 are lost; this is accepted.
  - t+2: state CLRWAIT, BUSY=1, ptr<=0.
  - t+3: state READ, BUSY=0.
- CMD_VLD while BUSY=1: command dropped and ERR<=1.
- Read handshake: RD_REQ at cycle t gives RD_VLD=1 at t+1 for exactly one cycle.
  - In READ: RD_DATA=byte[ptr] of the snapshot. Byte order is channel 0 LSB first, channels ascending. ptr<=ptr+1, wrapping from NB-1 to 0.
  - In IDLE, CAPTURE or CLRWAIT: RD_DATA=8'hFF and ptr is unchanged.
  - RD_DATA holds its value between RD_VLD pulses.
- TEND in READ or IDLE: state<=IDLE, ptr<=0. TEND in CAPTURE or CLRWAIT is ignored; the sequence completes.
- Simultaneous events:
  - CMD_VLD with TEND: the command wins (the TEND effect is applied first, then the command).
  - CMD_VLD with RD_REQ in READ: the read is served from the old snapshot with the old ptr, and the command is then processed.
  - A 8'h1n clear coinciding with a SNAP_CLR clear still yields a single-cycle CLR.
- Snapshot registers hold their value until the next CAPTURE or reset. Live counter changes outside CAPTURE never alter them.

Test Plan:
- Reset with counters at ch0..ch3 = 0x1234, 0x00FF, 0x8000, 0xFFFF; send 8'h01; issue 8 RD_REQ -> RD_DATA sequence 34,12,FF,00,00,80,FF,FF. A 9th RD_REQ returns 34 (wrap).
- Counters incrementing every cycle; send 8'h02 -> FREEZE and CLR=4'hF in the same single cycle (t+1). Snapshot equals CNTR at t+1, counters read 0 at t+2, BUSY high at t+1..t+2.
- Send 8'h12 then 8'h23; two RD_REQ -> CLR=4'b0100 for one cycle. Reads return ch3 snapshot bytes FF,FF.
- Send 8'h55 -> ERR=1, no CLR/FREEZE. Send 8'h01 at t, then 8'h01 at t+1 -> second one dropped, ERR stays 1. Send 8'h03 -> ERR=0.
- RD_REQ in IDLE -> RD_VLD at t+1 with RD_DATA=FF. In READ with ptr=3, TEND then RD_REQ -> FF returned, ptr=0.
- RST asserted during CAPTURE -> next cycle all outputs at reset values. A subsequent 8'h20 and RD_REQ returns 00.
